// File: rtl/video_timing_pkg.sv
// Mode table types and constants shared by the video timing generator and its ROM.
// Every table entry is built from literal constants, so all sums fold at elaboration.
package video_timing_pkg;

   localparam int TW        = 12;
   localparam int NUM_MODES = 4;

   localparam int MODE_640x480   = 0;
   localparam int MODE_800x600   = 1;
   localparam int MODE_1280x720  = 2;
   localparam int MODE_1920x1080 = 3;

   typedef struct packed {
      logic [TW-1:0] h_active;
      logic [TW-1:0] h_fp;
      logic [TW-1:0] h_sync;
      logic [TW-1:0] h_total;
      logic [TW-1:0] v_active;
      logic [TW-1:0] v_fp;
      logic [TW-1:0] v_sync;
      logic [TW-1:0] v_total;
      logic          hs_pol;
      logic          vs_pol;
   } mode_timing_t;

   // Decode-ready view: sync windows and last-count values precomputed per mode.
   typedef struct packed {
      logic [TW-1:0] h_active;
      logic [TW-1:0] h_sync_start;
      logic [TW-1:0] h_sync_end;
      logic [TW-1:0] h_last;
      logic [TW-1:0] v_active;
      logic [TW-1:0] v_sync_start;
      logic [TW-1:0] v_sync_end;
      logic [TW-1:0] v_last;
      logic          hs_pol;
      logic          vs_pol;
   } mode_decode_t;

   function automatic mode_timing_t mk_mode(input int ha, input int hf, input int hs,
                                            input int hb, input int va, input int vf,
                                            input int vs, input int vb, input logic pol);
      mode_timing_t t;
      t.h_active = TW'(ha);
      t.h_fp     = TW'(hf);
      t.h_sync   = TW'(hs);
      t.h_total  = TW'(ha + hf + hs + hb);
      t.v_active = TW'(va);
      t.v_fp     = TW'(vf);
      t.v_sync   = TW'(vs);
      t.v_total  = TW'(va + vf + vs + vb);
      t.hs_pol   = pol;
      t.vs_pol   = pol;
      return t;
   endfunction

   function automatic mode_decode_t derive(input mode_timing_t t);
      mode_decode_t d;
      d.h_active     = t.h_active;
      d.h_sync_start = t.h_active + t.h_fp;
      d.h_sync_end   = t.h_active + t.h_fp + t.h_sync;
      d.h_last       = t.h_total - TW'(1);
      d.v_active     = t.v_active;
      d.v_sync_start = t.v_active + t.v_fp;
      d.v_sync_end   = t.v_active + t.v_fp + t.v_sync;
      d.v_last       = t.v_total - TW'(1);
      d.hs_pol       = t.hs_pol;
      d.vs_pol       = t.vs_pol;
      return d;
   endfunction

   function automatic mode_decode_t mode_lut(input int code);
      case (code)
         MODE_800x600:   return derive(mk_mode(800, 40, 128, 88, 600, 1, 4, 23, 1'b1));
         MODE_1280x720:  return derive(mk_mode(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1));
         MODE_1920x1080: return derive(mk_mode(1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1));
         default:        return derive(mk_mode(640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      endcase
   endfunction

endpackage

// File: rtl/video_mode_table.sv
// Combinational ROM: active mode code to decode-ready timing (sync windows, last counts).
// Codes outside the table map to 640x480; the generator never selects them.
module video_mode_table
   import video_timing_pkg::*;
#(
   parameter int MODE_W = 4
) (
   input  logic [MODE_W-1:0] mode_sel,
   output mode_decode_t      timing
);

   assign timing = mode_lut(int'(mode_sel));

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-selectable video timing generator: HS/VS/DE, pixel coordinates and strobes.
// All outputs registered one cycle after the counters; mode changes land at frame end.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int CNT_W        = 12,
   parameter int MODE_W       = 4,
   parameter int DEFAULT_MODE = 0
) (
   input  logic              pixel_clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [MODE_W-1:0] mode,
   output logic [MODE_W-1:0] active_mode,
   output logic              mode_valid,
   output logic              hs,
   output logic              vs,
   output logic              de,
   output logic [CNT_W-1:0]  x,
   output logic [CNT_W-1:0]  y,
   output logic              frame_start,
   output logic              line_start
);

   localparam mode_decode_t      DEF_T    = mode_lut(DEFAULT_MODE);
   localparam logic [MODE_W-1:0] DEF_CODE = MODE_W'(DEFAULT_MODE);

   logic [MODE_W-1:0] req;
   logic [CNT_W-1:0]  h_cnt;
   logic [CNT_W-1:0]  v_cnt;
   mode_decode_t      t;
   logic              h_last, v_last, h_act, v_act, hs_on, vs_on, take_req;

   video_mode_table #(.MODE_W(MODE_W)) u_table (
      .mode_sel (active_mode),
      .timing   (t)
   );

   assign mode_valid = (req < MODE_W'(NUM_MODES));
   assign take_req   = mode_valid && (req != active_mode);

   assign h_last = (h_cnt == CNT_W'(t.h_last));
   assign v_last = (v_cnt == CNT_W'(t.v_last));
   assign h_act  = (h_cnt <  CNT_W'(t.h_active));
   assign v_act  = (v_cnt <  CNT_W'(t.v_active));
   assign hs_on  = (h_cnt >= CNT_W'(t.h_sync_start)) && (h_cnt < CNT_W'(t.h_sync_end));
   assign vs_on  = (v_cnt >= CNT_W'(t.v_sync_start)) && (v_cnt < CNT_W'(t.v_sync_end));

   // While disabled the counters sit at the origin, so a pending request can switch at once.
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         req         <= DEF_CODE;
         active_mode <= DEF_CODE;
         h_cnt       <= '0;
         v_cnt       <= '0;
      end else begin
         req <= mode;
         if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
            if (take_req) active_mode <= req;
         end else if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
               v_cnt <= '0;
               if (take_req) active_mode <= req;
            end else begin
               v_cnt <= v_cnt + 1'b1;
            end
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         hs          <= ~DEF_T.hs_pol;
         vs          <= ~DEF_T.vs_pol;
      end else if (!enable) begin
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         hs          <= ~t.hs_pol;
         vs          <= ~t.vs_pol;
      end else begin
         de          <= h_act && v_act;
         x           <= (h_act && v_act) ? h_cnt : '0;
         y           <= (h_act && v_act) ? v_cnt : '0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         line_start  <= (h_cnt == '0);
         hs          <= hs_on ? t.hs_pol : ~t.hs_pol;
         vs          <= vs_on ? t.vs_pol : ~t.vs_pol;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen; v_cnt is forced forward to reach frame ends quickly.
module tb_video_timing_gen;

   localparam int CNT_W  = 12;
   localparam int MODE_W = 4;

   logic              pixel_clock = 1'b0;
   logic              reset;
   logic              enable;
   logic [MODE_W-1:0] mode;
   logic [MODE_W-1:0] active_mode;
   logic              mode_valid, hs, vs, de, frame_start, line_start;
   logic [CNT_W-1:0]  x, y;

   int pass_cnt  = 0;
   int total_cnt = 0;

   video_timing_gen #(.CNT_W(CNT_W), .MODE_W(MODE_W), .DEFAULT_MODE(0)) dut (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .enable      (enable),
      .mode        (mode),
      .active_mode (active_mode),
      .mode_valid  (mode_valid),
      .hs          (hs),
      .vs          (vs),
      .de          (de),
      .x           (x),
      .y           (y),
      .frame_start (frame_start),
      .line_start  (line_start)
   );

   always #5 pixel_clock = ~pixel_clock;

   // Starts on a sampled line_start cycle (h=0) and walks to the next one.
   task automatic scan_line(input logic pol, output int period, output int hs_first,
                            output int hs_len, output int de_len, output int x_last,
                            output int y_last);
      period = 0; hs_first = -1; hs_len = 0; de_len = 0; x_last = 0; y_last = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i > 0 && line_start === 1'b1) begin
            period = i;
            return;
         end
         if (hs === pol) begin
            if (hs_first < 0) hs_first = i;
            hs_len++;
         end
         if (de === 1'b1) begin
            de_len++;
            x_last = int'(x);
            y_last = int'(y);
         end
         @(negedge pixel_clock);
      end
   endtask

   task automatic wait_ls(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge pixel_clock);
         if (line_start === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; mode = 4'd0;
      repeat (2) @(negedge pixel_clock);
      total_cnt++; if ({hs, vs, de, frame_start, line_start} !== 5'b11000) $display("FAIL reset_outs: got %b want 11000", {hs, vs, de, frame_start, line_start}); else pass_cnt++;
      total_cnt++; if (active_mode !== 4'd0 || mode_valid !== 1'b1) $display("FAIL reset_mode: got mode %0d valid %b want 0 1", active_mode, mode_valid); else pass_cnt++;
      total_cnt++; if (x !== 12'd0 || y !== 12'd0) $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); else pass_cnt++;
      mode = 4'd2;
      @(negedge pixel_clock) reset = 1'b0;
      repeat (3) @(negedge pixel_clock);
      total_cnt++; if (active_mode !== 4'd2) $display("FAIL disabled_switch: got %0d want 2", active_mode); else pass_cnt++;
      enable = 1'b1;
      repeat (300) @(negedge pixel_clock);
      total_cnt++; if ({de, hs, vs} !== 3'b100 || active_mode !== 4'd2) $display("FAIL mode2_midline: got de/hs/vs %b mode %0d want 100 2", {de, hs, vs}, active_mode); else pass_cnt++;
      mode = 4'd0;
      #2 reset = 1'b1;
      #1;
      total_cnt++; if ({hs, vs, de, frame_start, line_start} !== 5'b11000) $display("FAIL async_reset_outs: got %b want 11000", {hs, vs, de, frame_start, line_start}); else pass_cnt++;
      total_cnt++; if (active_mode !== 4'd0 || x !== 12'd0) $display("FAIL async_reset_mode: got mode %0d x %0d want 0 0", active_mode, x); else pass_cnt++;
      @(negedge pixel_clock) reset = 1'b0;
      @(negedge pixel_clock);
      total_cnt++; if ({frame_start, line_start, de} !== 3'b111 || x !== 12'd0 || y !== 12'd0) $display("FAIL release_first: got fs/ls/de %b xy %0d,%0d want 111 0,0", {frame_start, line_start, de}, x, y); else pass_cnt++;
   endtask

   task automatic test_mode0();
      int per, hf, hl, dl, xl, yl, n;
      bit ok;
      scan_line(1'b0, per, hf, hl, dl, xl, yl);
      total_cnt++; if (per !== 800) $display("FAIL m0_line_period: got %0d want 800", per); else pass_cnt++;
      total_cnt++; if (hf !== 656 || hl !== 96) $display("FAIL m0_hs: got start %0d len %0d want 656 96", hf, hl); else pass_cnt++;
      total_cnt++; if (dl !== 640 || xl !== 639) $display("FAIL m0_de: got len %0d xmax %0d want 640 639", dl, xl); else pass_cnt++;
      force dut.v_cnt = 12'd478;
      @(negedge pixel_clock);
      release dut.v_cnt;
      wait_ls(ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL m0_wait_479: got timeout want line_start"); else pass_cnt++;
      scan_line(1'b0, per, hf, hl, dl, xl, yl);
      total_cnt++; if (dl !== 640 || yl !== 479) $display("FAIL m0_last_active: got len %0d y %0d want 640 479", dl, yl); else pass_cnt++;
      scan_line(1'b0, per, hf, hl, dl, xl, yl);
      total_cnt++; if (dl !== 0 || per !== 800) $display("FAIL m0_line480: got de %0d per %0d want 0 800", dl, per); else pass_cnt++;
      n = 0;
      while (vs !== 1'b0 && n < 10000) begin @(negedge pixel_clock); n++; end
      total_cnt++; if (n !== 7200 || line_start !== 1'b1) $display("FAIL m0_vs_start: got %0d cycles ls %b want 7200 1", n, line_start); else pass_cnt++;
      n = 0;
      while (vs === 1'b0 && n < 5000) begin @(negedge pixel_clock); n++; end
      total_cnt++; if (n !== 1600) $display("FAIL m0_vs_len: got %0d want 1600", n); else pass_cnt++;
      n = 0;
      while (frame_start !== 1'b1 && n < 40000) begin @(negedge pixel_clock); n++; end
      total_cnt++; if (n !== 26400) $display("FAIL m0_vbp_to_frame: got %0d want 26400", n); else pass_cnt++;
   endtask

   task automatic test_mode_switch();
      int per, hf, hl, dl, xl, yl;
      bit ok;
      mode = 4'd2;
      scan_line(1'b0, per, hf, hl, dl, xl, yl);
      total_cnt++; if (per !== 800 || active_mode !== 4'd0) $display("FAIL sw_hold: got per %0d mode %0d want 800 0", per, active_mode); else pass_cnt++;
      force dut.v_cnt = 12'd523;
      @(negedge pixel_clock);
      release dut.v_cnt;
      wait_ls(ok);
      scan_line(1'b0, per, hf, hl, dl, xl, yl);
      total_cnt++; if (ok !== 1'b1 || per !== 800 || hl !== 96) $display("FAIL sw_last_line: got ok %b per %0d hs %0d want 1 800 96", ok, per, hl); else pass_cnt++;
      total_cnt++; if ({frame_start, de} !== 2'b11 || active_mode !== 4'd2 || x !== 12'd0 || y !== 12'd0) $display("FAIL sw_boundary: got fs/de %b mode %0d xy %0d,%0d want 11 2 0,0", {frame_start, de}, active_mode, x, y); else pass_cnt++;
      scan_line(1'b1, per, hf, hl, dl, xl, yl);
      total_cnt++; if (per !== 1650 || hf !== 1390 || hl !== 40 || dl !== 1280) $display("FAIL m2_line: got per %0d hs %0d/%0d de %0d want 1650 1390/40 1280", per, hf, hl, dl); else pass_cnt++;
   endtask

   task automatic test_invalid_mode();
      int per, hf, hl, dl, xl, yl;
      bit ok;
      mode = 4'd7;
      @(negedge pixel_clock);
      total_cnt++; if (mode_valid !== 1'b0) $display("FAIL inv_valid: got %b want 0", mode_valid); else pass_cnt++;
      force dut.v_cnt = 12'd748;
      @(negedge pixel_clock);
      release dut.v_cnt;
      wait_ls(ok);
      wait_ls(ok);
      total_cnt++; if (ok !== 1'b1 || frame_start !== 1'b1 || active_mode !== 4'd2) $display("FAIL inv_boundary: got fs %b mode %0d want 1 2", frame_start, active_mode); else pass_cnt++;
      scan_line(1'b1, per, hf, hl, dl, xl, yl);
      total_cnt++; if (per !== 1650) $display("FAIL inv_timing: got %0d want 1650", per); else pass_cnt++;
      mode = 4'd1;
      @(negedge pixel_clock);
      total_cnt++; if (mode_valid !== 1'b1 || active_mode !== 4'd2) $display("FAIL m1_pending: got valid %b mode %0d want 1 2", mode_valid, active_mode); else pass_cnt++;
      force dut.v_cnt = 12'd748;
      @(negedge pixel_clock);
      release dut.v_cnt;
      wait_ls(ok);
      wait_ls(ok);
      total_cnt++; if (ok !== 1'b1 || frame_start !== 1'b1 || active_mode !== 4'd1) $display("FAIL m1_boundary: got fs %b mode %0d want 1 1", frame_start, active_mode); else pass_cnt++;
      scan_line(1'b1, per, hf, hl, dl, xl, yl);
      total_cnt++; if (per !== 1056 || hf !== 840 || hl !== 128 || dl !== 800) $display("FAIL m1_line: got per %0d hs %0d/%0d de %0d want 1056 840/128 800", per, hf, hl, dl); else pass_cnt++;
   endtask

   task automatic test_enable_gap();
      int bad = 0;
      repeat (100) @(negedge pixel_clock);
      enable = 1'b0;
      @(negedge pixel_clock);
      total_cnt++; if ({de, hs, vs, frame_start, line_start} !== 5'b00000 || x !== 12'd0 || y !== 12'd0) $display("FAIL gap_first: got %b xy %0d,%0d want 00000 0,0", {de, hs, vs, frame_start, line_start}, x, y); else pass_cnt++;
      for (int i = 0; i < 49; i++) begin
         if (i == 10) mode = 4'd3;
         @(negedge pixel_clock);
         if ({de, hs, vs, frame_start, line_start, x, y} !== '0) bad++;
      end
      total_cnt++; if (bad !== 0) $display("FAIL gap_hold: got %0d active cycles want 0", bad); else pass_cnt++;
      total_cnt++; if (active_mode !== 4'd3) $display("FAIL gap_switch: got %0d want 3", active_mode); else pass_cnt++;
      enable = 1'b1;
      @(negedge pixel_clock);
      total_cnt++; if ({frame_start, line_start, de} !== 3'b111 || x !== 12'd0 || y !== 12'd0) $display("FAIL gap_resume: got fs/ls/de %b xy %0d,%0d want 111 0,0", {frame_start, line_start, de}, x, y); else pass_cnt++;
   endtask

   task automatic test_mode3();
      int per, hf, hl, dl, xl, yl;
      bit ok;
      scan_line(1'b1, per, hf, hl, dl, xl, yl);
      total_cnt++; if (per !== 2200 || hf !== 2008 || hl !== 44) $display("FAIL m3_line: got per %0d hs %0d/%0d want 2200 2008/44", per, hf, hl); else pass_cnt++;
      total_cnt++; if (dl !== 1920 || xl !== 1919) $display("FAIL m3_de: got len %0d xmax %0d want 1920 1919", dl, xl); else pass_cnt++;
      force dut.v_cnt = 12'd1078;
      @(negedge pixel_clock);
      release dut.v_cnt;
      wait_ls(ok);
      scan_line(1'b1, per, hf, hl, dl, xl, yl);
      total_cnt++; if (ok !== 1'b1 || dl !== 1920 || yl !== 1079) $display("FAIL m3_last_active: got ok %b len %0d y %0d want 1 1920 1079", ok, dl, yl); else pass_cnt++;
      force dut.v_cnt = 12'd1124;
      @(negedge pixel_clock);
      release dut.v_cnt;
      wait_ls(ok);
      total_cnt++; if (ok !== 1'b1 || frame_start !== 1'b1 || active_mode !== 4'd3) $display("FAIL m3_wrap: got fs %b mode %0d want 1 3", frame_start, active_mode); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode_switch();
      test_invalid_mode();
      test_enable_gap();
      test_mode3();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised, runtime-selectable video timing generator for the HDMI TX path.
- Produces HS/VS/DE plus pixel coordinates and frame/line strobes for the image output stage.
- Generalises the fixed 640x480p60 timing to a table of four CEA/VESA modes, selected by a mode code.
- Mode changes are applied glitch-free at frame boundaries; adds enable gating and a mode-valid status.

Parameters:
- CNT_W, 12, width of horizontal/vertical counters and x/y outputs (must hold 2199).
- MODE_W, 4, width of mode select.
- DEFAULT_MODE, 0, mode loaded at reset.

Ports:
- pixel_clock  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run timing; 0 = hold counters at 0, outputs inactive.
- mode  in  MODE_W  requested mode code (0..3 supported).
- active_mode  out  MODE_W  mode currently driving timing.
- mode_valid  out  1  1 when the registered request is a supported code.
- hs  out  1  horizontal sync, polarity per mode.
- vs  out  1  vertical sync, polarity per mode.
- de  out  1  data enable, high in active region.
- x  out  CNT_W  horizontal pixel index, valid when de=1.
- y  out  CNT_W  line index, valid when de=1.
- frame_start  out  1  one-cycle pulse at pixel (0,0).
- line_start  out  1  one-cycle pulse at h=0 of every line (all v).

Behaviour:
- Mode table (active/fp/sync/bp/total, sync polarity):
  - 0: 640x480p60, H 640/16/96/48/800, V 480/10/2/33/525, HS and VS negative.
  - 1: 800x600p60, H 800/40/128/88/1056, V 600/1/4/23/628, positive.
  - 2: 1280x720p60, H 1280/110/40/220/1650, V 720/5/5/20/750, positive.
  - 3: 1920x1080p60, H 1920/88/44/148/2200, V 1080/4/5/36/1125, positive.
- Line and frame order: active, front porch, sync, back porch. Counter origin h=0, v=0 is the first active pixel.
- h_cnt increments each enabled cycle and wraps at h_total-1 to 0. v_cnt increments on that wrap and wraps at v_total-1.
- Decode from (h_cnt, v_cnt), all outputs registered, latency 1 cycle; x, y, de, hs, vs, strobes are mutually aligned:
  - de = h<h_active AND v<v_active; x=h_cnt, y=v_cnt when de=1, else x=y=0.
  - hs asserted for h in [h_active+hfp, h_active+hfp+hsync).
  - vs asserted for whole lines v in [v_active+vfp, v_active+vfp+vsync), switching at h=0.
  - Asserted level = polarity bit; inactive level = inverse.
  - frame_start = (h=0 AND v=0); line_start = (h=0).
- Mode request:
  - mode is registered every cycle into req.
  - mode_valid = (req <= 3).
  - At the last pixel of a frame (h=h_total-1, v=v_total-1), if mode_valid and req != active_mode, active_mode <= req and counters restart at 0 under the new table.
  - Invalid req is ignored; timing continues unchanged.
  - A request changed several times within a frame: only the value present at the boundary is applied.
- enable=0:
  - h_cnt=v_cnt=0; de=0; x=y=0; strobes 0; hs/vs at inactive level of active_mode.
  - The pending mode request is applied immediately.
  - On enable rising, the first enabled cycle is (0,0); frame_start appears 1 cycle later.
- Reset (async, any time including mid-frame):
  - active_mode=DEFAULT_MODE, req=DEFAULT_MODE, counters 0.
  - de=0, x=y=0, frame_start=line_start=0, hs/vs at inactive level of DEFAULT_MODE, mode_valid=1.
- Widths: all comparisons are unsigned at CNT_W; table sums are computed as constants, with no runtime adders beyond the counters.

Decomposition:
- Package video_timing_pkg:
  - mode_timing_t struct (h/v active, fp, sync, total, hs_pol, vs_pol).
  - Mode code constants MODE_640x480, MODE_800x600, MODE_1280x720, MODE_1920x1080.
  - NUM_MODES=4.
- Sub-module video_mode_table: combinational ROM mapping active_mode to mode_timing_t, with precomputed sync start/end.
- video_timing_gen holds the counters, mode switching and output registers.

Test Plan:
- Reset asserted mid-frame in mode 2 -> same cycle: hs=vs=1 (mode 0 inactive), de=0, active_mode=0; after release, frame_start 1 cycle after the first enabled cycle.
- Mode 0 free-run one frame -> line period 800 cycles; hs low for 96 cycles starting at h=656; de high 307200 cycles per frame; vs low 1600 cycles starting at v=490; frame_start period 420000.
- Mode 3 -> line period 2200, hs high 44 cycles from h=2008; frame period 2475000; x reaches 1919, y reaches 1079.
- mode changes 0->2 at v=100 -> timing stays mode 0 until frame end; next cycle after (799,524) is (0,0) of mode 2; active_mode=2; no runt hs/vs.
- mode=7 -> mode_valid=0 after 1 cycle; active_mode and timing unchanged across the boundary; mode=1 then switches at the next boundary.
- enable low for 50 cycles mid-line -> de=0, hs/vs inactive; after enable returns, counting resumes from (0,0), with frame_start exactly 1 cycle later.
